// File: rtl/mseq_peak_sync.sv
// mseq_peak_sync
//   Frame synchroniser placed after the m-sequence correlator. It detects
//   correlation peaks, checks that they are spaced PERIOD valid samples
//   apart, declares lock after CONFIRM correctly spaced hits, and flywheels
//   through up to MAX_MISS consecutive missing peaks while locked.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_valid new correlation sample present on data
//   data       correlation value (unsigned)
//   sync       one-cycle frame sync pulse
//   locked     frame lock flag
//   phase      valid samples since the last anchor or slot
//   peak_val   value of the last accepted hit
//   miss_cnt   consecutive missed slots while locked
//
// state  | meaning
// SEARCH | no timing reference; waiting for the first peak
// VERIFY | anchored; counting correctly spaced hits toward CONFIRM
// LOCK   | frame locked; slots produce sync, misses are flywheeled

module mseq_peak_sync #(
  parameter int WIDTH    = 8,
  parameter int PERIOD   = 31,
  parameter int THRESH   = 56,
  parameter int CONFIRM  = 3,
  parameter int MAX_MISS = 2,
  localparam int PW      = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data,
  output logic             sync,
  output logic             locked,
  output logic [PW-1:0]    phase,
  output logic [WIDTH-1:0] peak_val,
  output logic [1:0]       miss_cnt
);

  localparam int CW = $clog2(CONFIRM + 1);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCK   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    conf, conf_nxt;
  logic [PW-1:0]    phase_nxt;
  logic [WIDTH-1:0] peak_nxt;
  logic [1:0]       miss_nxt;
  logic             sync_nxt;
  logic             hit, slot;
  logic [CW-1:0]    conf_inc;

  assign hit      = data_valid && (data >= WIDTH'(THRESH));
  assign slot     = data_valid && (phase == PW'(PERIOD - 1)) && (state != SEARCH);
  assign conf_inc = conf + CW'(1);

  always_comb begin
    state_nxt = state;
    conf_nxt  = conf;
    phase_nxt = phase;
    peak_nxt  = peak_val;
    miss_nxt  = miss_cnt;
    sync_nxt  = 1'b0;

    if (data_valid) begin
      phase_nxt = phase + PW'(1);
      case (state)
        SEARCH: begin
          phase_nxt = '0;
          if (hit) begin
            state_nxt = VERIFY;
            conf_nxt  = CW'(1);
            peak_nxt  = data;
          end
        end

        VERIFY: begin
          // slot takes priority: a hit on the slot is on-time, not early
          if (slot) begin
            phase_nxt = '0;
            if (hit) begin
              conf_nxt = conf_inc;
              peak_nxt = data;
              if (conf_inc == CW'(CONFIRM)) begin
                state_nxt = LOCK;
                sync_nxt  = 1'b1;
                miss_nxt  = '0;
              end
            end else begin
              state_nxt = SEARCH;
              conf_nxt  = '0;
            end
          end else if (hit) begin
            // early peak: the earlier anchor was probably noise
            conf_nxt  = CW'(1);
            phase_nxt = '0;
            peak_nxt  = data;
          end
        end

        LOCK: begin
          if (slot) begin
            phase_nxt = '0;
            if (hit) begin
              sync_nxt = 1'b1;
              miss_nxt = '0;
              peak_nxt = data;
            end else if (miss_cnt < 2'(MAX_MISS)) begin
              sync_nxt = 1'b1;
              miss_nxt = miss_cnt + 2'd1;
            end else begin
              state_nxt = SEARCH;
              miss_nxt  = '0;
              conf_nxt  = '0;
            end
          end
        end

        default: begin
          state_nxt = SEARCH;
          phase_nxt = '0;
          conf_nxt  = '0;
          miss_nxt  = '0;
        end
      endcase
    end else if (state != SEARCH && state != VERIFY && state != LOCK) begin
      state_nxt = SEARCH;
      phase_nxt = '0;
      conf_nxt  = '0;
      miss_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      conf     <= '0;
      phase    <= '0;
      peak_val <= '0;
      miss_cnt <= '0;
      sync     <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      conf     <= conf_nxt;
      phase    <= phase_nxt;
      peak_val <= peak_nxt;
      miss_cnt <= miss_nxt;
      sync     <= sync_nxt;
      locked   <= (state_nxt == LOCK);
    end
  end

endmodule

// File: tb/tb_mseq_peak_sync.sv
module tb_mseq_peak_sync;

  localparam int WIDTH    = 8;
  localparam int PERIOD   = 31;
  localparam int THRESH   = 56;
  localparam int CONFIRM  = 3;
  localparam int MAX_MISS = 2;
  localparam int PW       = $clog2(PERIOD);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             data_valid = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             sync, locked;
  logic [PW-1:0]    phase;
  logic [WIDTH-1:0] peak_val;
  logic [1:0]       miss_cnt;

  mseq_peak_sync #(
    .WIDTH(WIDTH), .PERIOD(PERIOD), .THRESH(THRESH),
    .CONFIRM(CONFIRM), .MAX_MISS(MAX_MISS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data(data),
    .sync(sync), .locked(locked), .phase(phase),
    .peak_val(peak_val), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: timing is tracked as a global count of valid samples
  // and the sample index of the most recent timing reference; the phase is
  // their difference. Modes: 0 searching, 1 verifying, 2 locked.
  int m_mode, m_conf, m_miss, m_peak, m_sync;
  int m_vidx, m_ref;

  function automatic void model_reset();
    m_mode = 0; m_conf = 0; m_miss = 0; m_peak = 0; m_sync = 0;
    m_vidx = 0; m_ref = 0;
  endfunction

  function automatic void model_step(input bit v, input int d);
    bit is_hit, is_slot;
    int ph;
    m_sync = 0;
    if (!v) return;
    is_hit  = (d >= THRESH);
    ph      = m_vidx - m_ref;
    is_slot = (ph == PERIOD - 1) && (m_mode != 0);
    m_vidx++;
    if (m_mode == 0) begin
      m_ref = m_vidx;
      if (is_hit) begin m_mode = 1; m_conf = 1; m_peak = d; end
    end else if (is_slot) begin
      m_ref = m_vidx;
      if (m_mode == 1) begin
        if (is_hit) begin
          m_conf++; m_peak = d;
          if (m_conf == CONFIRM) begin m_mode = 2; m_sync = 1; m_miss = 0; end
        end else begin
          m_mode = 0; m_conf = 0;
        end
      end else begin
        if (is_hit) begin m_sync = 1; m_miss = 0; m_peak = d; end
        else if (m_miss < MAX_MISS) begin m_sync = 1; m_miss++; end
        else begin m_mode = 0; m_miss = 0; m_conf = 0; end
      end
    end else if (m_mode == 1 && is_hit) begin
      m_ref = m_vidx; m_conf = 1; m_peak = d;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("sync",     int'(sync),     m_sync);
    chk("locked",   int'(locked),   (m_mode == 2) ? 1 : 0);
    chk("phase",    int'(phase),    m_vidx - m_ref);
    chk("peak_val", int'(peak_val), m_peak);
    chk("miss_cnt", int'(miss_cnt), m_miss);
  endtask

  // one clock: inputs applied now (just after an edge), model advanced with
  // them, outputs checked 1 time unit after the next rising edge
  task automatic cyc(input bit v, input int d);
    data_valid = v;
    data       = WIDTH'(d);
    @(posedge clk);
    model_step(v, d);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data       = 8'd62;
      @(posedge clk);
      #1;
      compare_all();
      chk("rst_locked_lit", int'(locked), 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic lock_pattern(input int pk);
    for (int c = 0; c <= 62; c++)
      cyc(1'b1, (c % 31 == 0) ? pk : 10);
  endtask

  initial begin
    int k;
    model_reset();
    #1;
    do_reset(3);

    // basic lock
    lock_pattern(62);
    chk("lock_sync_lit",   int'(sync),     1);
    chk("lock_locked_lit", int'(locked),   1);
    chk("lock_phase_lit",  int'(phase),    0);
    chk("lock_peak_lit",   int'(peak_val), 62);

    // flywheel through two misses, lose lock at the third
    for (int c = 0; c < 31; c++) cyc(1'b1, 10);
    chk("fly1_sync_lit", int'(sync), 1);
    chk("fly1_miss_lit", int'(miss_cnt), 1);
    for (int c = 0; c < 31; c++) cyc(1'b1, 10);
    chk("fly2_miss_lit", int'(miss_cnt), 2);
    for (int c = 0; c < 31; c++) cyc(1'b1, 10);
    chk("loss_locked_lit", int'(locked), 0);
    chk("loss_sync_lit",   int'(sync),   0);
    chk("loss_miss_lit",   int'(miss_cnt), 0);

    // threshold boundary
    do_reset(1);
    lock_pattern(55);
    chk("thr55_locked_lit", int'(locked), 0);
    do_reset(1);
    lock_pattern(56);
    chk("thr56_locked_lit", int'(locked), 1);

    // early peak in VERIFY re-anchors
    do_reset(1);
    for (int c = 0; c <= 76; c++) begin
      cyc(1'b1, (c == 0 || c == 14 || c == 45 || c == 76) ? 62 : 10);
      if (c == 62) chk("early_nolock_lit", int'(locked), 0);
    end
    chk("early_lock_lit", int'(sync) + int'(locked), 2);

    // stall while locked
    k = 0;
    while (k < 62) begin
      k++;
      cyc(1'b1, (k % 31 == 0) ? 70 : 10);
      if (k == 10) begin
        for (int s = 0; s < 5; s++) begin
          cyc(1'b0, 62);
          chk("stall_phase_lit", int'(phase), 10);
        end
      end
      if (k == 31) chk("stall_slot_sync_lit", int'(sync), 1);
    end
    chk("stall_peak_lit", int'(peak_val), 70);

    // async reset mid-lock
    for (int c = 0; c < 7; c++) cyc(1'b1, 10);
    chk("pre_rst_locked_lit", int'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_locked_lit", int'(locked), 0);
    chk("async_sync_lit",   int'(sync),   0);
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic: mostly periodic peaks with dropouts, stalls, noise
    k = 0;
    for (int i = 0; i < 4000; i++) begin
      bit v;
      int d;
      v = ($urandom_range(0, 9) != 0);
      if (v) k++;
      if (v && (k % PERIOD == 0) && ($urandom_range(0, 5) != 0))
        d = $urandom_range(THRESH, 255);
      else if ($urandom_range(0, 60) == 0)
        d = $urandom_range(THRESH - 2, 255);
      else
        d = $urandom_range(0, THRESH - 1);
      if ($urandom_range(0, 700) == 0) k = k + $urandom_range(1, 20);
      cyc(v, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
